store_packer: RTL and testbench

- Store-side counterpart of the load-path sign extender: takes a 16-bit register value from the execute stage and writes it to a 16-bit word-addressed data memory.
- Supports byte and word stores on a byte-addressed, little-endian address space.
- A byte store is a read-modify-write of the containing word, so only the addressed lane changes.
- Sits between the pipeline store port and the data-memory request interface.

---
 rtl/store_packer_pkg.sv | 25 ++
 rtl/store_packer_merge.sv | 24 ++
 rtl/store_packer.sv | 122 ++++++++++++
 tb/tb_store_packer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/store_packer_pkg.sv
// Shared definitions for the store packer: word/byte widths, the lane-select
// bit, the FSM state encoding and the byte-store range test.
// Optional feature macro: STORE_RANGE_CHECK_EN (uses range_fault below).
package store_packer_pkg;

    localparam int DATASIZE = 16;   // register / memory word width
    localparam int BYTESIZE = 8;    // byte lane width
    localparam int LANE_BIT = 0;    // address bit that selects the byte lane

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    // A byte value is representable if the upper bits are all zero
    // (unsigned 8-bit) or a proper sign extension of bit 7.
    function automatic logic range_fault(input logic [DATASIZE-1:0] d);
        logic [DATASIZE-BYTESIZE-1:0] hi;
        hi = d[DATASIZE-1:BYTESIZE];
        range_fault = !((hi == '0) || ((hi == '1) && d[BYTESIZE-1]));
    endfunction

endpackage

// File: rtl/store_packer_merge.sv
// store_merge: replaces one byte lane of a memory word with a new byte,
// leaving the other lane untouched (little-endian: lane 0 = bits [7:0]).
module store_merge
    import store_packer_pkg::*;
#(
    parameter int DATA_W = DATASIZE
) (
    input  logic [DATA_W-1:0]   i_old_word,
    input  logic [BYTESIZE-1:0] i_new_byte,
    input  logic                i_lane,
    output logic [DATA_W-1:0]   o_merged
);

    // Overlay the new byte onto the addressed lane of the old word.
    always_comb begin
        o_merged = i_old_word;
        if (i_lane) begin
            o_merged[DATA_W-1 -: BYTESIZE] = i_new_byte;
        end else begin
            o_merged[BYTESIZE-1:0] = i_new_byte;
        end
    end

endmodule

// File: rtl/store_packer.sv
// store_packer: writes a register value to word-addressed data memory as a
// word store or a read-modify-write byte store.
// Optional feature macro: STORE_RANGE_CHECK_EN flags byte stores whose value
// fits neither unsigned 8-bit nor sign-extended 8-bit form.
//
// Handshakes: a request is taken on the edge where req_valid & req_ready;
// req_ready is high only in IDLE. mem_rd is held until the edge where
// mem_rvalid is seen, mem_wr is held until the edge where mem_wack is seen;
// mem_rvalid outside RD and mem_wack outside WR are ignored.
module store_packer
    import store_packer_pkg::*;
#(
    parameter int DATA_W = DATASIZE,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_byte,
    output logic              done,
    output logic              misalign,
    output logic              range_err,
    output logic [ADDR_W-2:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wack,
    output logic [1:0]        dbg_state
);

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic [ADDR_W-1:0]   r_addr;
    logic [BYTESIZE-1:0] r_byte_data;
    logic                r_misalign;
    logic                r_range_err;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_merged;

    assign w_accept = req_valid && (r_state == IDLE);

    store_merge #(
        .DATA_W(DATA_W)
    ) u_merge (
        .i_old_word(mem_rdata),
        .i_new_byte(r_byte_data),
        .i_lane    (r_addr[LANE_BIT]),
        .o_merged  (w_merged)
    );

    // Next-state decode; the store type is resolved once, at accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (req_byte) begin
                        w_next = RD;
                    end else if (req_addr[LANE_BIT]) begin
                        w_next = FIN;
                    end else begin
                        w_next = WR;
                    end
                end
            end
            RD:      if (mem_rvalid) w_next = WR;
            WR:      if (mem_wack) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register plus request latches and the outgoing write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_byte_data <= '0;
            r_misalign  <= 1'b0;
            r_range_err <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr      <= req_addr;
                r_byte_data <= req_data[BYTESIZE-1:0];
                r_misalign  <= !req_byte && req_addr[LANE_BIT];
`ifdef STORE_RANGE_CHECK_EN
                r_range_err <= req_byte && range_fault(req_data);
`else
                r_range_err <= 1'b0;
`endif
                if (!req_byte && !req_addr[LANE_BIT]) begin
                    r_wdata <= req_data;
                end
            end else if ((r_state == RD) && mem_rvalid) begin
                r_wdata <= w_merged;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign done      = (r_state == FIN);
    assign misalign  = (r_state == FIN) && r_misalign;
`ifdef STORE_RANGE_CHECK_EN
    assign range_err = (r_state == FIN) && r_range_err;
`else
    assign range_err = 1'b0;
`endif
    assign mem_rd    = (r_state == RD);
    assign mem_wr    = (r_state == WR);
    assign mem_addr  = r_addr[ADDR_W-1:1];
    assign mem_wdata = r_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer with a queue of expected memory writes
// checked by a responding memory model.
module tb_store_packer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        req_byte;
  logic        done;
  logic        misalign;
  logic        range_err;
  logic [14:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic        mem_wack;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // responder configuration and monitors
  int          rd_wait = 0;
  int          wr_wait = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [15:0] rd_word = 16'h0000;
  logic [30:0] exp_q[$];

  store_packer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_byte  (req_byte),
    .done      (done),
    .misalign  (misalign),
    .range_err (range_err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_wack  (mem_wack),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // memory model: answers strobes after the configured wait, pops the
  // expected-write queue on every accepted write
  always @(negedge clk) begin
    if (!rst) begin
      check("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
    end
    if (mem_rd) begin
      rd_cycles++;
      if (rd_cnt >= rd_wait) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_word;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'($urandom);
        rd_cnt++;
      end
    end else begin
      mem_rvalid = 1'b0;
      rd_cnt     = 0;
    end
    if (mem_wr) begin
      wr_cycles++;
      if (wr_cnt >= wr_wait) begin
        mem_wack = 1'b1;
        check("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("wr_word", {1'b0, mem_addr, mem_wdata}, {1'b0, exp_q.pop_front()});
        end
      end else begin
        mem_wack = 1'b0;
        wr_cnt++;
      end
    end else begin
      mem_wack = 1'b0;
      wr_cnt   = 0;
    end
  end

  // driver: one store, expectations derived here from the request
  task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic b,
                          input logic [15:0] rw, input int rwait, input int wwait);
    int          exp_lat;
    int          lat;
    logic        mis;
    logic        rerr;
    logic [15:0] wd;
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    mis  = !b && a[0];
    rerr = 1'b0;
`ifdef STORE_RANGE_CHECK_EN
    rerr = b && !((d[15:8] == 8'h00) || ((d[15:8] == 8'hFF) && d[7]));
`endif
    wd = b ? (a[0] ? {d[7:0], rw[7:0]} : {rw[15:8], d[7:0]}) : d;
    exp_lat = mis ? 1 : (b ? 3 + rwait + wwait : 2 + wwait);
    if (!mis) exp_q.push_back({a[15:1], wd});
    rd_wait = rwait; wr_wait = wwait; rd_word = rw;
    rd_cycles = 0; wr_cycles = 0;
    req_valid = 1'b1; req_addr = a; req_data = d; req_byte = b;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_data  = 16'($urandom);
        req_byte  = 1'($urandom);
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    check("done_latency", lat, exp_lat);
    check("misalign", {31'd0, misalign}, {31'd0, mis});
    check("range_err", {31'd0, range_err}, {31'd0, rerr});
    check("rd_cycles", rd_cycles, b ? rwait + 1 : 0);
    check("wr_cycles", wr_cycles, mis ? 0 : wwait + 1);
    @(negedge clk);
    check("done_one_cycle", {30'd0, done, misalign}, 32'd0);
  endtask

  initial begin
    int dn;
    logic [15:0] a;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_byte = 1'b0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_flags", {28'd0, done, misalign, range_err, 1'b0}, 32'd0);
    check("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    check("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    // directed stores
    do_store(16'h0010, 16'hBEEF, 1'b0, 16'h0000, 0, 0);
    do_store(16'h0021, 16'h0055, 1'b1, 16'h1234, 0, 0);
    do_store(16'h0020, 16'hFF80, 1'b1, 16'h1234, 2, 3);
    do_store(16'h0003, 16'h7777, 1'b0, 16'h0000, 0, 0);
    do_store(16'h0031, 16'h0170, 1'b1, 16'hABCD, 0, 0);
    do_store(16'h0044, 16'hFF12, 1'b1, 16'h5A5A, 1, 0);
    do_store(16'hFFFE, 16'h8001, 1'b0, 16'h0000, 0, 2);

    // random stores
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      do_store(a, 16'($urandom), 1'($urandom), 16'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // reset while waiting for write acknowledge: store is abandoned
    @(negedge clk);
    wr_wait = 20;
    req_valid = 1'b1; req_addr = 16'h0040; req_data = 16'hA5A5; req_byte = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_wr", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
    check("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    dn = 0;
    for (int n = 0; n < 6; n++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("rst_mid_no_done", dn, 0);

    // a store after the abandoned one still works
    do_store(16'h0050, 16'h1357, 1'b0, 16'h0000, 0, 1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
